// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter that shares one Montgomery multiplier among N_REQ requesters.
// Captures the winner's operands, pulses mm_start, waits for mm_done and returns the product.
module mont_mul_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 110
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       result,
  output logic               busy,
  output logic [15:0]        ops_count,
  output logic               mm_start,
  output logic [W-1:0]       mm_a,
  output logic [W-1:0]       mm_b,
  input  logic [W-1:0]       mm_r,
  input  logic               mm_done
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [W-1:0]      result_q, result_d;
  logic [W-1:0]      mm_a_q, mm_a_d;
  logic [W-1:0]      mm_b_q, mm_b_d;
  logic              busy_q, busy_d;
  logic              mm_start_q, mm_start_d;
  logic [15:0]       ops_count_q, ops_count_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   owner_q, owner_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cidx;
  int unsigned       cand;

  // Search starts one past the last granted index and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cidx      = '0;
    cand      = 0;
    for (int unsigned o = 1; o <= N_REQ; o++) begin
      cand = int'(last_q) + o;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cidx = IdxW'(cand);
      if (!win_found && req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    result_d    = result_q;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    busy_d      = busy_q;
    mm_start_d  = 1'b0;
    ops_count_d = ops_count_q;
    last_d      = last_q;
    owner_d     = owner_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          owner_d    = win_idx;
          mm_a_d     = req_a[int'(win_idx)*W +: W];
          mm_b_d     = req_b[int'(win_idx)*W +: W];
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          busy_d     = 1'b1;
          mm_start_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        last_d  = owner_q;
        state_d = StRun;
      end
      StRun: begin
        if (mm_done) begin
          result_d    = mm_r;
          done_d      = gnt_q;
          ops_count_d = ops_count_q + 16'd1;
          state_d     = StDone;
        end
      end
      StDone: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      busy_q      <= 1'b0;
      mm_start_q  <= 1'b0;
      ops_count_q <= '0;
      last_q      <= IdxW'(N_REQ - 1);
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      busy_q      <= busy_d;
      mm_start_q  <= mm_start_d;
      ops_count_q <= ops_count_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign ops_count = ops_count_q;
  assign mm_start  = mm_start_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Bench for mont_mul_arbiter: behavioural multiplier with programmable latency, completion
// scoreboard, a vector table for single operations and hand sequences for multi-cycle cases.
module tb_mont_mul_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 110;
  localparam logic [W-1:0] KA = 110'h2A995E7EFE396E61B2D77E92FF2C;
  localparam logic [W-1:0] KR = 110'h14BB69D2E2E57941FFE3B745BAD6;

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           k;
    logic [W-1:0] res;
    bit           chg;
    bit           drop;
  } vec_t;

  typedef struct {
    logic [N-1:0] owner;
    logic [W-1:0] res;
  } sb_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic [15:0]    ops_count;
  logic           mm_start;
  logic [W-1:0]   mm_a;
  logic [W-1:0]   mm_b;
  logic [W-1:0]   mm_r;
  logic           mm_done;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mdl_k = 1;
  int          mdl_cnt = 0;
  logic        mdl_done = 1'b0;
  int          ms_cnt = 0;
  logic [15:0] exp_ops = '0;
  sb_t         sb[$];
  vec_t        vecs[7];

  mont_mul_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .ops_count (ops_count),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_r      (mm_r),
    .mm_done   (mm_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stand-in: known Montgomery pair, otherwise a truncated plain product.
  // mm_done is first high in RUN cycle mdl_k.
  always_comb begin
    if (mm_a == KA && mm_b == KA) mm_r = KR;
    else mm_r = mm_a * mm_b;
  end
  assign mm_done = mdl_done;

  always @(posedge clk) begin
    if (mm_start) begin
      mdl_cnt  <= 1;
      mdl_done <= (mdl_k == 1);
    end else if (!mdl_done) begin
      mdl_cnt  <= mdl_cnt + 1;
      mdl_done <= (mdl_cnt + 1 == mdl_k);
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (mm_start) ms_cnt++;
    if (rst_n && done != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, '0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        exp_ops = exp_ops + 16'd1;
        check("done_owner", done, e.owner);
        check("result", result, e.res);
        check("ops_count", ops_count, exp_ops);
      end
    end
  end

  task automatic chk_zero(input string pfx);
    check({pfx, "_gnt"}, gnt, '0);
    check({pfx, "_done"}, done, '0);
    check({pfx, "_busy"}, busy, '0);
    check({pfx, "_mm_start"}, mm_start, '0);
    check({pfx, "_result"}, result, '0);
    check({pfx, "_mm_a"}, mm_a, '0);
    check({pfx, "_mm_b"}, mm_b, '0);
    check({pfx, "_ops_count"}, ops_count, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = '0;
    sb.delete();
  endtask

  task automatic run_op(input vec_t v);
    int           cyc;
    bit           got;
    logic [N-1:0] oh;
    oh = 4'b0001 << v.idx;
    mdl_k = v.k;
    req_a[v.idx*W +: W] = v.a;
    req_b[v.idx*W +: W] = v.b;
    sb.push_back('{oh, v.res});
    ms_cnt = 0;
    req[v.idx] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check("grant", gnt, oh);
      if (cyc == 2) begin
        if (v.chg) req_a[v.idx*W +: W] = v.a + 2;
        if (v.drop) req[v.idx] = 1'b0;
      end
      if (done != '0) got = 1'b1;
    end
    check("latency", cyc, v.k + 2);
    check("gnt_at_done", gnt, oh);
    check("start_pulses", ms_cnt, 1);
    req[v.idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_after", busy, 1'b0);
  endtask

  task automatic wait_done(output int cyc);
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done != '0) got = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    logic [N-1:0] seen;
    logic [W-1:0] big;

    big = 110'h1 << 109;
    vecs[0] = '{1, KA, KA, 3, KR, 1'b0, 1'b0};
    vecs[1] = '{3, 110'd5, 110'd3, 1, 110'd15, 1'b0, 1'b0};
    vecs[2] = '{3, 110'h1234, 110'h10, 2, 110'h12340, 1'b0, 1'b0};
    vecs[3] = '{3, big, 110'd2, 4, 110'd0, 1'b0, 1'b0};
    vecs[4] = '{0, 110'd5, 110'd3, 4, 110'd15, 1'b1, 1'b0};
    vecs[5] = '{2, 110'hFF, 110'hFF, 5, 110'hFE01, 1'b0, 1'b1};
    vecs[6] = '{2, '1, '1, 2, 110'd1, 1'b0, 1'b0};

    req = '0;
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    chk_zero("reset");

    foreach (vecs[i]) run_op(vecs[i]);

    // Simultaneous requests from reset, k=5.
    do_reset();
    mdl_k = 5;
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = W'(i + 2);
      req_b[i*W +: W] = 110'd10;
      sb.push_back('{4'b0001 << i, W'((i + 2) * 10)});
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
        check("simul_idle_gap", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("simul_busy_start", busy, 1'b1);
        wait_done(cyc);
        cyc = cyc + 1;
      end else begin
        wait_done(cyc);
      end
      check("simul_done", done, 4'b0001 << i);
      check("simul_latency", cyc, 7);
      req[i] = 1'b0;
    end

    // Fairness with requesters 0 and 2 held.
    do_reset();
    mdl_k = 2;
    req_a[0*W +: W] = 110'd4;
    req_a[2*W +: W] = 110'd6;
    req_b[0*W +: W] = 110'd1;
    req_b[2*W +: W] = 110'd1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back((i % 2 == 0) ? '{4'b0001, 110'd4} : '{4'b0100, 110'd6});
    end
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_done(cyc);
      check("fair_order", done, (i % 2 == 0) ? 4'b0001 : 4'b0100);
    end
    req = '0;

    // Reset while RUN: the late mm_done must not produce a completion.
    do_reset();
    run_op(vecs[1]);
    mdl_k = 6;
    req_a[1*W +: W] = 110'd9;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = '0;
    chk_zero("midrun");
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | done;
    end
    check("late_mm_done_seen", mm_done, 1'b1);
    check("late_done_ignored", seen, '0);
    run_op('{0, 110'd7, 110'd6, 2, 110'd42, 1'b0, 1'b0});

    // Counter wrap from 16'hFFFF.
    force dut.ops_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.ops_count_q;
    @(posedge clk);
    @(negedge clk);
    check("ops_preload", ops_count, 16'hFFFF);
    exp_ops = 16'hFFFF;
    run_op(vecs[2]);
    check("ops_wrapped", ops_count, 16'h0000);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_mul_arbiter.md
# mont_mul_arbiter

Round-robin arbiter and sequencer that shares one `mont_mul_p` Montgomery multiplier among up to four requesters, such as curve-add, inversion and Zoo walk units. It latches the granted requester's operands and starts the multiplier with a one-cycle `mm_start` pulse on the multiplier's `reset` input. It waits for `mm_done`, then returns the product with a one-cycle `done` pulse to the owner. It sits between the ECC datapath units and a single `mont_mul_p` instance in the 80 MHz domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..4.
- `W`, `` `R_Bits`` (110): operand and result width.
- `clk` in 1: system clock (CLOCK_80 domain).
- `rst` in 1: synchronous, active-low reset.
- `req` in N_REQ: request per requester; held high until its `done`.
- `req_a` in N_REQ*W: operand A per requester; requester i uses slice [i*W +: W].
- `req_b` in N_REQ*W: operand B per requester, same slicing.
- `gnt` out N_REQ: one-hot owner; high from grant through the DONE cycle.
- `done` out N_REQ: one-cycle completion pulse to the owner.
- `result` out W: product, valid while `done` is high; held until the next completion.
- `busy` out 1: high in any state other than IDLE.
- `ops_count` out 16: number of completed operations; wraps.
- `mm_start` out 1: drives `mont_mul_p.reset`; one-cycle start pulse.
- `mm_a` out W: registered operand to the multiplier.
- `mm_b` out W: registered operand to the multiplier.
- `mm_r` in W: multiplier result.
- `mm_done` in 1: multiplier done; cleared by the multiplier while `mm_start` is high.

## Operation
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - If any `req` bit is high, pick the winner by round-robin.
  - The search starts at index `(last+1) mod N_REQ`, where `last` is the last granted index (reset value N_REQ-1, so requester 0 wins first).
  - On a winner: latch `mm_a`/`mm_b` from the winner's slices, set `gnt[winner]`, go to START.
- START:
  - `mm_start`=1 for exactly one cycle.
  - Update `last` to the winner.
  - Go to RUN.
- RUN:
  - `mm_start`=0.
  - Sample `mm_done` each cycle.
  - When it is high: latch `result`<=`mm_r`, go to DONE.
- DONE:
  - `done[owner]`=1 and `gnt[owner]`=1.
  - `ops_count` increments by 1; 16'hFFFF wraps to 0.
  - Go to IDLE.
- `req` is sampled only in IDLE. A requester must drop `req` in the cycle after `done`; a `req` still high then is a new request.
- Operands are captured once, on entry to START. Changes to `req_a`/`req_b` after grant have no effect.
- `req[owner]` dropping during START or RUN does not abort the operation. It runs to completion and `done` still pulses.
- Requests arriving while busy wait. There is no queue depth beyond the held `req` lines.
- Reset (`rst`=0 at a clock edge), in any state including mid-RUN:
  - FSM goes to IDLE.
  - `gnt`, `done`, `busy`, `mm_start`, `result`, `mm_a`, `mm_b`, `ops_count` all go to 0.
  - `last` goes to N_REQ-1.
  - An in-flight multiplier operation is discarded. Its late `mm_done` is ignored because it is only sampled in RUN.

## Timing
- Edge E0: IDLE samples `req`.
- Cycle after E0: START; `gnt` rises and `mm_start`=1.
- Next cycle: RUN.
- If `mm_done` is first high in RUN cycle k (k≥1), the DONE cycle follows immediately: `done` and `result` are valid there.
- Request-to-`done` latency: 2 + k cycles after the request is sampled.
- Next grant is possible in the cycle after IDLE re-entry. Minimum back-to-back gap is one IDLE cycle between a DONE and the next START.
- All outputs are registered; there is no combinational path from `req` to `gnt` or from `mm_done` to `done`.
- `mm_a`/`mm_b` are stable from START through DONE.

## Test plan
- **Single request.** Stimulus: `req[1]`=1 with A=B=110'h2A995E7EFE396E61B2D77E92FF2C, real `mont_mul_p` attached. Required:
  - `gnt`=4'b0010 and one START cycle with `mm_start`=1.
  - `done`=4'b0010 pulse with `result`=110'h14BB69D2E2E57941FFE3B745BAD6.
  - `ops_count`=1.
- **Simultaneous requests.** Stimulus: `req`=4'b1111 from reset, each requester dropping `req` after its `done`; behavioural multiplier with k=5. Required:
  - Grant order 0,1,2,3.
  - Each `done` 7 cycles after its IDLE sample.
  - `busy` low exactly one cycle between operations.
- **Fairness.**
  - Stimulus: `req[0]` and `req[2]` held continuously. Required: grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
  - Stimulus: only `req[3]` toggled. Required: 3 is granted every time.
- **Operand capture.** Stimulus: change `req_a[0]` from 5 to 7 during RUN (model r=a*b, b=3). Required: `result`=15.
- **Request drop.** Stimulus: `req[2]` drops during RUN. Required: `done[2]` still pulses and `ops_count` still increments.
- **Reset mid-RUN.** Stimulus: `rst`=0 for one edge during RUN, and `mm_done` later goes high. Required:
  - All outputs are 0 on the next cycle.
  - No `done` is issued from the late `mm_done`.
  - A new `req[0]` gets a normal grant.
  - Separately: preload `ops_count` to 16'hFFFF via 65535 operations or force; the next completion gives 0.
